// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Width that can hold every occupancy value 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module fifo_mem_sdp #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of arbitrary depth with programmable almost-full/empty
// thresholds, synchronous flush and a clearable high-water mark.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  FIFO_DEPTH = 8,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = fifo_cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  input  logic                  hwm_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      hwm
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, r_hwm, w_count_next;
  fifo_status_t      r_stat;
  logic              w_full, w_empty, w_wr_acc, w_rd_acc;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
  endfunction

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full  && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;

  always_comb begin
    w_count_next = r_count;
    if (flush)                      w_count_next = '0;
    else if (w_wr_acc && !w_rd_acc) w_count_next = r_count + CNT_W'(1);
    else if (!w_wr_acc && w_rd_acc) w_count_next = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stat   <= '0;
      r_hwm    <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_rd_acc) r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count          <= w_count_next;
      r_stat.wr_ack    <= w_wr_acc;
      r_stat.overflow  <= wr_en && w_full  && !flush;
      r_stat.underflow <= rd_en && w_empty && !flush;
      // A flush drives count_next to 0, so the max keeps hwm unless cleared.
      if (hwm_clr)                    r_hwm <= w_count_next;
      else if (w_count_next > r_hwm)  r_hwm <= w_count_next;
    end
  end

  fifo_mem_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_out)
  );

  assign wr_ack      = r_stat.wr_ack;
  assign overflow    = r_stat.overflow;
  assign underflow   = r_stat.underflow;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count >= af_thresh);
  assign almostempty = (r_count <= ae_thresh);
  assign count       = r_count;
  assign hwm         = r_hwm;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed plus random bench for sync_fifo_prog (depth 6) against a queue model.
module tb_sync_fifo_prog;

  localparam int DW = 16;
  localparam int D  = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, flush, hwm_clr;
  logic [DW-1:0] data_in;
  logic [CW-1:0] af_thresh, ae_thresh;
  logic [DW-1:0] data_out;
  logic          wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic [CW-1:0] count, hwm;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ack, m_ovf, m_udf;
  int            m_hwm;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .hwm_clr(hwm_clr),
    .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .count(count), .hwm(hwm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit fl, em, wacc, racc;
    int n;
    if (rst) begin
      q.delete(); m_dout = '0; m_ack = 0; m_ovf = 0; m_udf = 0; m_hwm = 0;
    end else if (flush) begin
      q.delete(); m_ack = 0; m_ovf = 0; m_udf = 0;
      if (hwm_clr) m_hwm = 0;
    end else begin
      fl = (q.size() == D);
      em = (q.size() == 0);
      wacc = wr_en && !fl;
      racc = rd_en && !em;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(data_in);
      m_ack = wacc; m_ovf = wr_en && fl; m_udf = rd_en && em;
      n = q.size();
      if (hwm_clr) m_hwm = n;
      else if (n > m_hwm) m_hwm = n;
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almostfull", 32'(almostfull), 32'(q.size() >= int'(af_thresh)));
    chk("almostempty", 32'(almostempty), 32'(q.size() <= int'(ae_thresh)));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("wr_ack", 32'(wr_ack), 32'(m_ack));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("hwm", 32'(hwm), 32'(m_hwm));
  endtask

  task automatic step(input bit w, input bit r, input bit f, input bit h, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; flush = f; hwm_clr = h; data_in = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; flush = 0; hwm_clr = 0; data_in = '0;
    af_thresh = 3'd5; ae_thresh = 3'd1;
    #1;
    step(0, 0, 0, 0, '0);
    step(1, 1, 1, 1, 16'hFFFF);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_hwm", 32'(hwm), 0);
    rst = 0;

    // fill and overflow
    for (int i = 0; i < D; i++) begin
      step(1, 0, 0, 0, 16'(16'hA0 + i));
      chk("fill_ack", 32'(wr_ack), 1);
      chk("fill_cnt", 32'(count), 32'(i + 1));
    end
    chk("fill_full", 32'(full), 1);
    step(1, 0, 0, 0, 16'h00A6);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_cnt", 32'(count), 6);

    // drain and underflow
    for (int i = 0; i < D; i++) begin
      step(0, 1, 0, 0, '0);
      chk("drain_data", 32'(data_out), 32'(16'hA0 + i));
    end
    chk("drain_empty", 32'(empty), 1);
    step(0, 1, 0, 0, '0);
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_hold", 32'(data_out), 32'h00A5);

    // pointer wrap
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'(16'hB0 + 16 * k + i));
      for (int i = 0; i < 4; i++) begin
        step(0, 1, 0, 0, '0);
        chk("wrap_data", 32'(data_out), 32'(16'hB0 + 16 * k + i));
      end
    end

    // simultaneous read/write at full, empty and mid
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 16'(16'hC0 + i));
    step(1, 1, 0, 0, 16'h00CF);
    chk("both_full_cnt", 32'(count), 5);
    chk("both_full_ovf", 32'(overflow), 1);
    chk("both_full_ack", 32'(wr_ack), 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, '0);
    step(1, 1, 0, 0, 16'h00D0);
    chk("both_empty_cnt", 32'(count), 1);
    chk("both_empty_udf", 32'(underflow), 1);
    step(1, 0, 0, 0, 16'h00D1);
    step(1, 0, 0, 0, 16'h00D2);
    step(1, 1, 0, 0, 16'h00D3);
    chk("both_mid_cnt", 32'(count), 3);
    chk("both_mid_ack", 32'(wr_ack), 1);

    // thresholds
    af_thresh = 3'd4; ae_thresh = 3'd1;
    step(0, 0, 1, 0, '0);
    chk("thr_ae0", 32'(almostempty), 1);
    for (int i = 0; i < D; i++) begin
      step(1, 0, 0, 0, 16'(16'hE0 + i));
      chk("thr_af", 32'(almostfull), 32'(i + 1 >= 4));
      chk("thr_ae", 32'(almostempty), 32'(i + 1 <= 1));
    end
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 16'(16'hE8 + i));
    chk("thr_af_before", 32'(almostfull), 0);
    af_thresh = 3'd2;
    #1;
    chk("thr_af_same_cycle", 32'(almostfull), 1);
    af_thresh = 3'd0; ae_thresh = 3'd6;
    #1;
    chk("thr_af_zero", 32'(almostfull), 1);
    chk("thr_ae_depth", 32'(almostempty), 1);
    af_thresh = 3'd4; ae_thresh = 3'd1;

    // flush and high-water mark
    step(0, 0, 1, 1, '0);
    chk("hwm_clr_flush", 32'(hwm), 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'(16'hF0 + i));
    chk("hwm_five", 32'(hwm), 5);
    step(1, 0, 1, 0, 16'h00FF);
    chk("flush_cnt", 32'(count), 0);
    chk("flush_ack", 32'(wr_ack), 0);
    chk("flush_hwm", 32'(hwm), 5);
    step(0, 0, 0, 1, '0);
    chk("hwm_clr", 32'(hwm), 0);

    // reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 16'(16'h10 + i));
    step(0, 1, 0, 0, '0);
    rst = 1;
    step(1, 1, 0, 0, 16'h0077);
    chk("mid_rst_cnt", 32'(count), 0);
    chk("mid_rst_dout", 32'(data_out), 0);
    chk("mid_rst_ack", 32'(wr_ack), 0);
    chk("mid_rst_hwm", 32'(hwm), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    rst = 0;

    // random traffic
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) begin
        af_thresh = 3'($urandom_range(0, 7));
        ae_thresh = 3'($urandom_range(0, 7));
      end
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
           16'($urandom));
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
